match_ack_handler: RTL and testbench
====================================

# match_ack_handler

Downstream consumer of the byte-stream pattern detector. It takes the detector's `found_pattern` flag and counts each detection. It returns the `ack` level-toggle the detector needs to leave its post-match hold states, and drives a one-cycle event pulse plus a stretched LED indication. Its `ack` output connects directly to the detector's `ack` input, so the two blocks form a closed handshake loop.

## Interface
Parameters:
- `ACK_DELAY`, 4: cycles from detection to `ack` toggle; legal range 1..255.
- `STRETCH`, 8: cycles `led` stays high after the latest detection; legal range 1..255.
- `TIMEOUT`, 16: cycles `found_pattern` may stay high after the `ack` toggle before an error is flagged; legal range 2..255.
- `CNT_W`, 8: width of the match counter.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `found_pattern`  in  1  level from the detector; high while a completed pattern is held.
- `count_clr`  in  1  synchronous clear of `match_count`, `overflow` and `error`.
- `ack`  out  1  level-toggle acknowledge to the detector.
- `match_pulse`  out  1  one-cycle pulse per accepted detection.
- `match_count`  out  CNT_W  number of accepted detections; saturating.
- `overflow`  out  1  sticky; set when an increment is attempted at the maximum count.
- `led`  out  1  stretched detection indicator.
- `busy`  out  1  high in any state other than IDLE.
- `error`  out  1  sticky; set on release timeout.

## Operation
- `found_pattern` is registered into `f_q`. A detection is accepted only when the FSM is in IDLE, `found_pattern` is 1 and `f_q` is 0 (rising edge). A level that stays high never retriggers.
- FSM states and transitions:
  - **IDLE**: on an accepted detection, go to DELAY, load `dcnt = ACK_DELAY-1`, assert `match_pulse`, increment the count, and load the LED counter with `STRETCH`.
  - **DELAY**: if `dcnt == 0`, toggle `ack`, clear `tcnt` and go to RELEASE; otherwise decrement `dcnt`.
  - **RELEASE**:
    - `found_pattern == 0`: go to IDLE.
    - Otherwise, if `tcnt == TIMEOUT-1`: set `error` and go to IDLE.
    - Otherwise: increment `tcnt`.
- Counter rules:
  - `match_count` increments by 1 and saturates at 2^CNT_W−1.
  - An increment attempted at the maximum sets `overflow` and leaves the count unchanged.
  - `count_clr` has priority over a same-cycle increment: the count becomes 0 and `overflow` clears. `match_pulse` and `led` still fire for that detection.
- LED rules:
  - `led = (led_cnt != 0)`.
  - `led_cnt` decrements each cycle while nonzero.
  - A new detection reloads it to `STRETCH` (retrigger).
- `ack` is a level, never a pulse. It toggles exactly once per accepted detection, including when the detection ends in a timeout.
- The block does not modify `found_pattern` semantics. Detections arriving while `busy` is high are impossible by construction (the input is already high) and are ignored.

## Timing
- Reset values: `ack=0`, `match_pulse=0`, `match_count=0`, `overflow=0`, `led=0`, `busy=0`, `error=0`, `f_q=0`, state IDLE, all counters 0.
- Reset is asynchronous. Asserting `reset_n` mid-DELAY or mid-RELEASE returns the block to IDLE immediately and forces `ack` to 0 without a toggle.
- The cycle numbers below are clock edges, with edge k being the edge that samples `found_pattern=1` with `f_q=0`:
  - **Edge k**: `match_pulse`, `busy`, `led` and the incremented count become visible; `match_pulse` is high for exactly that cycle.
  - **Edge k+ACK_DELAY**: `ack` toggles.
  - **RELEASE**: if the detector drops `found_pattern` within one cycle of the toggle, `busy` falls two edges after the `ack` toggle.
  - **Next detection**: the earliest next accepted detection requires `found_pattern` to be low for at least one sample.
- Timeout: `error` rises at the edge where `tcnt == TIMEOUT-1`, which is `TIMEOUT` edges after entering RELEASE with `found_pattern` still high.
- `count_clr` takes effect at the next edge and is independent of FSM state. It does not affect `ack` or the FSM.

## Test plan
1. **Basic detection**: defaults; `found_pattern` rises at edge 10 and falls 1 cycle after `ack` toggles. Required: `match_pulse` high only in cycle 10–11, `match_count=1`, `ack` 0→1 at edge 14, `busy` low by edge 16, `led` high for 8 cycles.
2. **Back-to-back detections**: three detections each separated by one low cycle. Required: `ack` sequence 1,0,1, `match_count=3`, `led` retriggered and continuously high, `error=0`.
3. **Saturation and clear**: CNT_W=2; five detections. Required: count sequence 1,2,3,3,3, `overflow` set at the 4th detection. Then `count_clr` in the same cycle as the 6th detection. Required: `match_count=0`, `overflow=0`, `match_pulse=1`.
4. **Timeout**: `found_pattern` held high for 40 cycles. Required: exactly one `match_pulse`, one `ack` toggle, `error=1` at edge k+4+16, return to IDLE, and no retrigger until `found_pattern` goes low and then high again.
5. **Reset mid-handshake**: `reset_n` asserted low 2 cycles into DELAY. Required: all outputs at reset values asynchronously, and no `ack` toggle after release.
6. **Loop with detector**: stream "xboabz" into the detector with its `ack` driven by this block. Required: `match_count=1`, and the detector returns to its initial state (its `found_pattern` goes to 0) within 2 cycles after the `ack` toggle.

Source files
------------

// File: rtl/match_ack_handler.sv
// Acknowledge side of the pattern-detector handshake: counts accepted detections,
// returns a toggled ack after a fixed delay, and watches for a stuck found_pattern.
module match_ack_handler #(
   parameter int ACK_DELAY = 4,
   parameter int STRETCH   = 8,
   parameter int TIMEOUT   = 16,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             found_pattern,
   input  logic             count_clr,
   output logic             ack,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_count,
   output logic             overflow,
   output logic             led,
   output logic             busy,
   output logic             error
);

   typedef enum logic [1:0] {IDLE, DELAY, RELEASE} state_t;

   localparam logic [7:0]       DLY_LOAD = 8'(ACK_DELAY - 1);
   localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [7:0]       LED_LOAD = 8'(STRETCH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state_reg, state_next;
   logic             f_q;
   logic [7:0]       dcnt_reg, dcnt_next;
   logic [7:0]       tcnt_reg, tcnt_next;
   logic [7:0]       led_cnt_reg, led_cnt_next;
   logic             ack_reg, ack_next;
   logic             pulse_reg, pulse_next;
   logic             ovf_reg, ovf_next;
   logic             err_reg, err_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             accept;
   logic             timeout;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         f_q         <= 1'b0;
         dcnt_reg    <= '0;
         tcnt_reg    <= '0;
         led_cnt_reg <= '0;
         ack_reg     <= 1'b0;
         pulse_reg   <= 1'b0;
         ovf_reg     <= 1'b0;
         err_reg     <= 1'b0;
         count_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         f_q         <= found_pattern;
         dcnt_reg    <= dcnt_next;
         tcnt_reg    <= tcnt_next;
         led_cnt_reg <= led_cnt_next;
         ack_reg     <= ack_next;
         pulse_reg   <= pulse_next;
         ovf_reg     <= ovf_next;
         err_reg     <= err_next;
         count_reg   <= count_next;
      end
   end

   // Handshake sequencing; found_pattern is only edge-qualified while IDLE.
   always_comb begin
      state_next = state_reg;
      dcnt_next  = dcnt_reg;
      tcnt_next  = tcnt_reg;
      ack_next   = ack_reg;
      accept     = 1'b0;
      timeout    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (found_pattern && !f_q) begin
               accept     = 1'b1;
               dcnt_next  = DLY_LOAD;
               state_next = DELAY;
            end
         end
         DELAY: begin
            if (dcnt_reg == 8'd0) begin
               ack_next   = !ack_reg;
               tcnt_next  = '0;
               state_next = RELEASE;
            end else begin
               dcnt_next = dcnt_reg - 8'd1;
            end
         end
         RELEASE: begin
            if (!found_pattern) begin
               state_next = IDLE;
            end else if (tcnt_reg == TMO_LAST) begin
               timeout    = 1'b1;
               state_next = IDLE;
            end else begin
               tcnt_next = tcnt_reg + 8'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Clear beats a same-cycle increment or timeout; pulse and LED still fire.
   always_comb begin
      pulse_next   = accept;
      count_next   = count_reg;
      ovf_next     = ovf_reg;
      err_next     = err_reg;
      led_cnt_next = led_cnt_reg;
      if (count_clr) begin
         count_next = '0;
         ovf_next   = 1'b0;
         err_next   = 1'b0;
      end else begin
         if (accept) begin
            if (count_reg == CNT_MAX) ovf_next = 1'b1;
            else                      count_next = count_reg + 1'b1;
         end
         if (timeout) err_next = 1'b1;
      end
      if (accept)                   led_cnt_next = LED_LOAD;
      else if (led_cnt_reg != 8'd0) led_cnt_next = led_cnt_reg - 8'd1;
   end

   assign ack         = ack_reg;
   assign match_pulse = pulse_reg;
   assign match_count = count_reg;
   assign overflow    = ovf_reg;
   assign led         = (led_cnt_reg != 8'd0);
   assign busy        = (state_reg != IDLE);
   assign error       = err_reg;

endmodule

// File: tb/tb_match_ack_handler.sv
// Bench for match_ack_handler: directed tables and sequences plus random stimulus,
// all cross-checked every cycle against a timestamp-based reference model.
module tb_match_ack_handler;

   localparam int AD  = 4;
   localparam int ST  = 8;
   localparam int TO  = 16;
   localparam int CW  = 8;
   localparam int CW2 = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic found_pattern = 1'b0;
   logic count_clr = 1'b0;

   logic          ack, match_pulse, overflow, led, busy, error;
   logic [CW-1:0] match_count;
   logic           ack2, pulse2, ovf2, led2, busy2, err2;
   logic [CW2-1:0] count2;

   always #5 clk = ~clk;

   match_ack_handler #(.ACK_DELAY(AD), .STRETCH(ST), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .found_pattern(found_pattern), .count_clr(count_clr),
      .ack(ack), .match_pulse(match_pulse), .match_count(match_count), .overflow(overflow),
      .led(led), .busy(busy), .error(error));

   match_ack_handler #(.ACK_DELAY(AD), .STRETCH(ST), .TIMEOUT(TO), .CNT_W(CW2)) dut_sat (
      .clk(clk), .reset_n(reset_n), .found_pattern(found_pattern), .count_clr(count_clr),
      .ack(ack2), .match_pulse(pulse2), .match_count(count2), .overflow(ovf2),
      .led(led2), .busy(busy2), .error(err2));

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: tracks the edge of the last accepted detection and derives
   // every output from elapsed time since then.
   bit m_busy, m_prev, m_ack, m_pulse, m_err, m_have_det, m_o1, m_o2;
   int m_det, m_last, m_c1, m_c2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_prev = 0; m_ack = 0; m_pulse = 0; m_err = 0;
      m_have_det = 0; m_o1 = 0; m_o2 = 0; m_det = 0; m_last = 0; m_c1 = 0; m_c2 = 0;
   endtask

   function automatic bit m_led();
      return m_have_det && ((cyc - m_last) < ST);
   endfunction

   task automatic model_edge();
      bit acc, tmo;
      cyc++;
      if (!reset_n) begin
         model_reset();
         return;
      end
      acc = 0; tmo = 0; m_pulse = 0;
      if (m_busy) begin
         if (cyc == m_det + AD) m_ack = !m_ack;
         else if (cyc > m_det + AD) begin
            if (!found_pattern) m_busy = 0;
            else if (cyc == m_det + AD + TO) begin
               m_busy = 0;
               tmo = 1;
            end
         end
      end else if (found_pattern && !m_prev) begin
         acc = 1; m_busy = 1; m_det = cyc; m_last = cyc; m_have_det = 1; m_pulse = 1;
      end
      if (count_clr) begin
         m_c1 = 0; m_c2 = 0; m_o1 = 0; m_o2 = 0; m_err = 0;
      end else begin
         if (acc) begin
            if (m_c1 == (1 << CW) - 1) m_o1 = 1; else m_c1++;
            if (m_c2 == (1 << CW2) - 1) m_o2 = 1; else m_c2++;
         end
         if (tmo) m_err = 1;
      end
      if (acc) $display("detection at edge %0d: count=%0d count_sat=%0d", cyc, m_c1, m_c2);
      m_prev = found_pattern;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("pulse", match_pulse, m_pulse);
      chk("ack", ack, m_ack);
      chk("count", match_count, m_c1);
      chk("overflow", overflow, m_o1);
      chk("led", led, m_led());
      chk("busy", busy, m_busy);
      chk("error", error, m_err);
      chk("sat_pulse", pulse2, m_pulse);
      chk("sat_ack", ack2, m_ack);
      chk("sat_count", count2, m_c2);
      chk("sat_overflow", ovf2, m_o2);
      chk("sat_led", led2, m_led());
      chk("sat_busy", busy2, m_busy);
      chk("sat_error", err2, m_err);
   endtask

   task automatic do_reset();
      found_pattern = 0;
      count_clr = 0;
      reset_n = 0;
      tick();
      reset_n = 1;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      if (busy) chk({name, "_idle_timeout"}, busy, 0);
   endtask

   task automatic detect_once(input bit clr, output bit p, output int c, output bit o);
      found_pattern = 1;
      count_clr = clr;
      tick();
      p = pulse2; c = int'(count2); o = ovf2;
      found_pattern = 0;
      count_clr = 0;
      wait_idle("t3");
      tick();
   endtask

   typedef struct {
      bit found;
      bit pulse;
      bit ack;
      bit busy;
      bit led;
      int count;
   } vec_t;

   initial begin
      vec_t tbl[20];
      int   exp_cnt[5] = '{1, 2, 3, 3, 3};
      bit   exp_ovf[5] = '{0, 0, 0, 1, 1};
      bit   p, o, started, ref_ack, ack_pre, det_hold, det_prev_a, det_ack_ref;
      int   c, gaps, n, k, pulses, toggles, err_edge, toggle_i, fall_i, run;
      int   ack_seq[3];
      string s;
      byte   b;

      for (int i = 1; i <= 20; i++) begin
         tbl[i-1].found = (i >= 10 && i <= 15);
         tbl[i-1].pulse = (i == 10);
         tbl[i-1].ack   = (i >= 10 + AD);
         tbl[i-1].busy  = (i >= 10 && i <= 15);
         tbl[i-1].led   = (i >= 10 && i < 10 + ST);
         tbl[i-1].count = (i >= 10) ? 1 : 0;
      end

      model_reset();
      tick();
      tick();
      chk("rst_ack", ack, 0);
      chk("rst_pulse", match_pulse, 0);
      chk("rst_count", match_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_led", led, 0);
      chk("rst_busy", busy, 0);
      chk("rst_error", error, 0);
      reset_n = 1;

      // Basic detection: rise sampled at edge 10, dropped after the toggle
      for (int i = 0; i < 20; i++) begin
         found_pattern = tbl[i].found;
         tick();
         chk("t1_pulse", match_pulse, tbl[i].pulse);
         chk("t1_ack", ack, tbl[i].ack);
         chk("t1_busy", busy, tbl[i].busy);
         chk("t1_led", led, tbl[i].led);
         chk("t1_count", match_count, tbl[i].count);
      end

      // Back-to-back detections separated by a single low sample
      do_reset();
      tick();
      gaps = 0;
      started = 0;
      for (int d = 0; d < 3; d++) begin
         found_pattern = 1;
         ref_ack = ack;
         n = 0;
         do begin
            tick();
            if (match_pulse) started = 1;
            if (started && !led) gaps++;
            n++;
         end while (ack == ref_ack && n < 30);
         ack_seq[d] = int'(ack);
         found_pattern = 0;
         tick();
         if (started && !led) gaps++;
      end
      wait_idle("t2");
      chk("t2_ack0", ack_seq[0], 1);
      chk("t2_ack1", ack_seq[1], 0);
      chk("t2_ack2", ack_seq[2], 1);
      chk("t2_count", match_count, 3);
      chk("t2_led_gaps", gaps, 0);
      chk("t2_error", error, 0);

      // Saturation on the 2-bit instance, then clear coinciding with a detection
      do_reset();
      tick();
      for (int d = 0; d < 5; d++) begin
         detect_once(0, p, c, o);
         chk("t3_count", c, exp_cnt[d]);
         chk("t3_overflow", o, exp_ovf[d]);
      end
      detect_once(1, p, c, o);
      chk("t3_clr_count", c, 0);
      chk("t3_clr_overflow", o, 0);
      chk("t3_clr_pulse", p, 1);

      // Timeout with found_pattern stuck high
      do_reset();
      tick();
      found_pattern = 1;
      pulses = 0; toggles = 0; k = -1; err_edge = -1;
      for (int i = 0; i < 40; i++) begin
         ref_ack = ack;
         tick();
         if (match_pulse) begin
            pulses++;
            if (k < 0) k = i;
         end
         if (ack != ref_ack) toggles++;
         if (error && err_edge < 0) err_edge = i;
      end
      chk("t4_pulses", pulses, 1);
      chk("t4_toggles", toggles, 1);
      chk("t4_error_edge", err_edge - k, AD + TO);
      chk("t4_idle", busy, 0);
      found_pattern = 0;
      tick();
      found_pattern = 1;
      tick();
      chk("t4_retrigger", match_pulse, 1);
      found_pattern = 0;
      wait_idle("t4");

      // Asynchronous reset two cycles into DELAY
      do_reset();
      tick();
      found_pattern = 1;
      tick();
      tick();
      tick();
      #3;
      reset_n = 0;
      found_pattern = 0;
      #1;
      chk("t5_ack", ack, 0);
      chk("t5_busy", busy, 0);
      chk("t5_led", led, 0);
      chk("t5_count", match_count, 0);
      chk("t5_pulse", match_pulse, 0);
      model_reset();
      tick();
      reset_n = 1;
      for (int i = 0; i < 12; i++) tick();
      chk("t5_no_toggle", ack, 0);

      // Closed loop with a stand-in detector that matches "ab" and releases on ack change
      do_reset();
      tick();
      s = "xboabz";
      det_hold = 0; det_prev_a = 0; det_ack_ref = 0;
      toggle_i = -100; fall_i = -1;
      for (int i = 0; i < 24; i++) begin
         ack_pre = ack;
         b = (i < s.len()) ? s[i] : 8'h2e;
         tick();
         if (ack != ack_pre) toggle_i = i;
         if (det_hold) begin
            if (ack_pre != det_ack_ref) begin
               det_hold = 0;
               fall_i = i;
            end
         end else if (det_prev_a && b == "b") begin
            det_hold = 1;
            det_ack_ref = ack_pre;
         end
         det_prev_a = (b == "a");
         found_pattern = det_hold;
      end
      chk("t6_count", match_count, 1);
      chk("t6_release_window", (fall_i - toggle_i >= 1) && (fall_i - toggle_i <= 2), 1);
      chk("t6_idle", busy, 0);

      // Random runs of found_pattern, long enough to hit timeouts, with sparse clears
      do_reset();
      run = 0;
      for (int i = 0; i < 3000; i++) begin
         if (run == 0) begin
            found_pattern = !found_pattern;
            run = $urandom_range(1, 25);
         end
         run--;
         count_clr = ($urandom_range(0, 40) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
